fetch_stall_ctrl: RTL and testbench

- Sequencing controller for the instruction-fetch unit of the 5-stage MIPS pipeline.
- Decides each cycle whether the PC advances (pc_en) and which next-PC source is taken (pc_sel).
- Freezes the IF/ID register and bubbles ID/EX on data hazards.
- Tracks the multi-cycle mult/div unit with an internal busy FSM and counter, so that dependent HI/LO instructions stall in D.

---
 rtl/fetch_stall_ctrl.sv | 128 ++++++++++++
 tb/tb_fetch_stall_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/fetch_stall_ctrl.sv
// IF-stage sequencing for the 5-stage MIPS pipeline: PC enable/select, IF/ID freeze, ID/EX bubble, mult/div busy tracking.
// Optional FETCH_STALL_CNT_EN adds a 32-bit stall_cnt output counting stalled cycles.
module fetch_stall_ctrl #(
    parameter int unsigned MULT_LAT = 5,
    parameter int unsigned DIV_LAT  = 10,
    parameter int unsigned CNT_W    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       d_br,
    input  logic       d_j,
    input  logic       d_jr,
    input  logic       d_use_rs,
    input  logic       d_use_rt,
    input  logic [4:0] d_rs,
    input  logic [4:0] d_rt,
    input  logic       d_md,
    input  logic       e_mem_rd,
    input  logic       e_reg_wr,
    input  logic [4:0] e_dst,
    input  logic       m_mem_rd,
    input  logic [4:0] m_dst,
    input  logic       e_md_start,
    input  logic       e_md_div,
    output logic       pc_en,
    output logic [1:0] pc_sel,
    output logic       ifid_en,
    output logic       idex_flush,
    output logic       md_busy
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [31:0] stall_cnt
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic match_e, match_m;
    logic hz_load, hz_br, hz_md, stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A start while already busy is ignored: no reload, no state change.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (e_md_start) begin
                    state_d = BUSY;
                    cnt_d   = e_md_div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
                end
            end
            BUSY: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign md_busy = (state_q == BUSY);

    // Register 0 is hard-wired zero and never creates a dependency.
    assign match_e = (e_dst != '0) &&
                     ((d_use_rs && (d_rs == e_dst)) || (d_use_rt && (d_rt == e_dst)));
    assign match_m = (m_dst != '0) &&
                     ((d_use_rs && (d_rs == m_dst)) || (d_use_rt && (d_rt == m_dst)));

    assign hz_load = e_mem_rd && match_e;
    assign hz_br   = (d_br || d_jr) && ((e_reg_wr && match_e) || (m_mem_rd && match_m));
    assign hz_md   = d_md && (e_md_start || md_busy);
    assign stall   = hz_load || hz_br || hz_md;

    always_comb begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        idex_flush = 1'b0;
        pc_sel     = 2'b00;
        if (reset || stall) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end else if (d_jr) begin
            pc_sel = 2'b11;
        end else if (d_j) begin
            pc_sel = 2'b10;
        end else if (d_br) begin
            pc_sel = 2'b01;
        end
    end

`ifdef FETCH_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else if (stall) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stall_ctrl.sv
// Scoreboard bench for fetch_stall_ctrl: stimulus pushes expected outputs, a negedge monitor pops and compares.
module tb_fetch_stall_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       d_br, d_j, d_jr, d_use_rs, d_use_rt, d_md;
    logic [4:0] d_rs, d_rt, e_dst, m_dst;
    logic       e_mem_rd, e_reg_wr, m_mem_rd, e_md_start, e_md_div;
    logic       pc_en, ifid_en, idex_flush, md_busy;
    logic [1:0] pc_sel;
`ifdef FETCH_STALL_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] sc_base;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string      name;
        logic [5:0] exp; // {pc_en, pc_sel, ifid_en, idex_flush, md_busy}
    } exp_t;

    exp_t sb_q[$];

    fetch_stall_ctrl #(.MULT_LAT(5), .DIV_LAT(10), .CNT_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .d_br       (d_br),
        .d_j        (d_j),
        .d_jr       (d_jr),
        .d_use_rs   (d_use_rs),
        .d_use_rt   (d_use_rt),
        .d_rs       (d_rs),
        .d_rt       (d_rt),
        .d_md       (d_md),
        .e_mem_rd   (e_mem_rd),
        .e_reg_wr   (e_reg_wr),
        .e_dst      (e_dst),
        .m_mem_rd   (m_mem_rd),
        .m_dst      (m_dst),
        .e_md_start (e_md_start),
        .e_md_div   (e_md_div),
        .pc_en      (pc_en),
        .pc_sel     (pc_sel),
        .ifid_en    (ifid_en),
        .idex_flush (idex_flush),
        .md_busy    (md_busy)
`ifdef FETCH_STALL_CNT_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Monitor: one expectation per cycle, sampled mid-cycle.
    initial begin
        exp_t       e;
        logic [5:0] act;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e   = sb_q.pop_front();
                act = {pc_en, pc_sel, ifid_en, idex_flush, md_busy};
                checks++;
                if (act !== e.exp) begin
                    failures++;
                    $display("FAIL %s: got {pc_en,pc_sel,ifid_en,idex_flush,md_busy}=%b_%b_%b_%b_%b expected %b_%b_%b_%b_%b",
                             e.name, act[5], act[4:3], act[2], act[1], act[0],
                             e.exp[5], e.exp[4:3], e.exp[2], e.exp[1], e.exp[0]);
                end
            end
        end
    end

    task automatic clr();
        d_br = 0; d_j = 0; d_jr = 0; d_use_rs = 0; d_use_rt = 0; d_md = 0;
        d_rs = 0; d_rt = 0; e_dst = 0; m_dst = 0;
        e_mem_rd = 0; e_reg_wr = 0; m_mem_rd = 0; e_md_start = 0; e_md_div = 0;
    endtask

    // Inputs are already applied; record the expectation, then move to the next cycle.
    task automatic step(input string name, input logic en, input logic [1:0] sel,
                        input logic ifid, input logic flush, input logic busy);
        exp_t e;
        e.name = name;
        e.exp  = {en, sel, ifid, flush, busy};
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        clr();
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Reset held three cycles.
        for (int unsigned i = 0; i < 3; i++) step("reset_hold", 0, 2'b00, 0, 1, 0);
        reset = 1'b0;
        step("after_reset", 1, 2'b00, 1, 0, 0);

        // Load-use on rs: one stall, then the load has moved to M.
        e_mem_rd = 1; e_dst = 8; d_use_rs = 1; d_rs = 8;
        step("load_use_stall", 0, 2'b00, 0, 1, 0);
        e_mem_rd = 0; e_dst = 0; m_mem_rd = 1; m_dst = 8;
        step("load_use_release", 1, 2'b00, 1, 0, 0);
        clr();
        e_mem_rd = 1; e_dst = 0; d_use_rs = 1; d_rs = 0;
        step("load_use_r0", 1, 2'b00, 1, 0, 0);
        clr();
        e_reg_wr = 1; e_dst = 7; d_use_rt = 1; d_rt = 7;
        step("alu_dep_no_stall", 1, 2'b00, 1, 0, 0);
        clr();

        // beq waiting on a load in M.
        d_br = 1; d_use_rt = 1; d_rt = 9; m_mem_rd = 1; m_dst = 9;
        step("beq_m_load_stall", 0, 2'b00, 0, 1, 0);
        m_mem_rd = 0; m_dst = 0;
        step("beq_release", 1, 2'b01, 1, 0, 0);
        m_mem_rd = 1; m_dst = 0; d_rt = 0;
        step("beq_m_load_r0", 1, 2'b01, 1, 0, 0);
        clr();

        // jr waiting on an ALU result in E.
        d_jr = 1; d_use_rs = 1; d_rs = 5; e_reg_wr = 1; e_dst = 5;
        step("jr_e_wr_stall", 0, 2'b00, 0, 1, 0);
        clr();
        d_jr = 1; d_br = 1;
        step("jr_over_br", 1, 2'b11, 1, 0, 0);
        clr();
        d_j = 1; d_br = 1;
        step("j_over_br", 1, 2'b10, 1, 0, 0);
        clr();

        // mult starts at t with mflo in D: stalls t..t+5, busy t+1..t+5.
`ifdef FETCH_STALL_CNT_EN
        sc_base = stall_cnt;
`endif
        e_md_start = 1; e_md_div = 0; d_md = 1;
        step("mult_start", 0, 2'b00, 0, 1, 0);
        e_md_start = 0; e_md_div = 0;
        for (int unsigned i = 0; i < 5; i++) step("mult_busy", 0, 2'b00, 0, 1, 1);
`ifdef FETCH_STALL_CNT_EN
        checks++;
        if (stall_cnt !== sc_base + 32'd6) begin
            failures++;
            $display("FAIL stall_cnt_mult: got %0d expected %0d", stall_cnt - sc_base, 6);
        end
`endif
        step("mflo_issue", 1, 2'b00, 1, 0, 0);
        clr();

        // div start, reset pulsed while cnt == 4.
        e_md_start = 1; e_md_div = 1;
        step("div_start", 1, 2'b00, 1, 0, 0);
        clr();
        for (int unsigned i = 0; i < 6; i++) step("div_busy", 1, 2'b00, 1, 0, 1);
        reset = 1; d_md = 1;
        step("div_reset", 0, 2'b00, 0, 1, 0);
        reset = 0;
        step("mfhi_after_reset", 1, 2'b00, 1, 0, 0);
        clr();
        step("idle_after_reset", 1, 2'b00, 1, 0, 0);

        for (int unsigned i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
        if (sb_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
